// File: rtl/pad_in_filter.sv
// -----------------------------------------------------------------------------
// pad_in_filter
//
// Per-pad input conditioning between the padring input bus and the peripheral
// inputs. Each lane has a two-flop synchroniser, an optional glitch filter
// with a shared programmable stability threshold, and single-cycle rise/fall
// event pulses derived from the conditioned level.
//
// Ports
//   clk_i            peripheral clock; all state lives in this domain
//   rst_i            synchronous active-high reset
//   pad_in_i         raw pad levels, asynchronous to clk_i
//   filter_en_i      per-lane filter enable (clk_i domain, quasi-static)
//   filter_cycles_i  shared threshold T; a change needs T+1 stable cycles
//   pad_in_o         conditioned levels (registered)
//   rise_o           one-cycle pulse in the cycle pad_in_o goes 0->1
//   fall_o           one-cycle pulse in the cycle pad_in_o goes 1->0
// -----------------------------------------------------------------------------
module pad_in_filter #(
    parameter int NPads = 66,
    parameter int CntW  = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NPads-1:0] pad_in_i,
    input  logic [NPads-1:0] filter_en_i,
    input  logic [CntW-1:0]  filter_cycles_i,
    output logic [NPads-1:0] pad_in_o,
    output logic [NPads-1:0] rise_o,
    output logic [NPads-1:0] fall_o
);

    logic [NPads-1:0] sync1_r;
    logic [NPads-1:0] sync2_r;
    logic [NPads-1:0] out_r;
    logic [NPads-1:0] rise_r;
    logic [NPads-1:0] fall_r;
    logic [CntW-1:0]  cnt_r      [NPads];

    logic [NPads-1:0] out_next_s;
    logic [CntW-1:0]  cnt_next_s [NPads];

    // Per-lane filter decision: next conditioned level and next counter value.
    always_comb begin
        for (int i = 0; i < NPads; i++) begin
            out_next_s[i] = out_r[i];
            cnt_next_s[i] = cnt_r[i];
            if (!filter_en_i[i]) begin
                // Bypass: follow the synchroniser, keep the counter idle so a
                // later enable starts counting from zero.
                out_next_s[i] = sync2_r[i];
                cnt_next_s[i] = {CntW{1'b0}};
            end else if (sync2_r[i] == out_r[i]) begin
                // Input agrees with the output: any partial excursion is dropped.
                cnt_next_s[i] = {CntW{1'b0}};
            end else if (cnt_r[i] >= filter_cycles_i) begin
                // '>=' rather than '==' so lowering T mid-count still commits
                // at the next edge instead of counting on to wrap.
                out_next_s[i] = sync2_r[i];
                cnt_next_s[i] = {CntW{1'b0}};
            end else begin
                cnt_next_s[i] = cnt_r[i] + CntW'(1);
            end
        end
    end

    // State registers: synchroniser, filter counters, output level and the
    // edge pulses (computed from the level transition being committed, which
    // is the same as comparing the output with its one-cycle-delayed copy).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_r <= {NPads{1'b0}};
            sync2_r <= {NPads{1'b0}};
            out_r   <= {NPads{1'b0}};
            rise_r  <= {NPads{1'b0}};
            fall_r  <= {NPads{1'b0}};
            for (int i = 0; i < NPads; i++) begin
                cnt_r[i] <= {CntW{1'b0}};
            end
        end else begin
            sync1_r <= pad_in_i;
            sync2_r <= sync1_r;
            out_r   <= out_next_s;
            rise_r  <= out_next_s & ~out_r;
            fall_r  <= ~out_next_s & out_r;
            for (int i = 0; i < NPads; i++) begin
                cnt_r[i] <= cnt_next_s[i];
            end
        end
    end

    assign pad_in_o = out_r;
    assign rise_o   = rise_r;
    assign fall_o   = fall_r;

endmodule

// File: tb/tb_pad_in_filter.sv
// -----------------------------------------------------------------------------
// tb_pad_in_filter
//
// Directed self-checking bench for pad_in_filter (NPads=66, CntW=16).
// Inputs are driven 1 time unit after a rising edge; outputs are sampled at
// the same point, so "after edge k" means the value observed following the
// k-th step since the stimulus change.
// -----------------------------------------------------------------------------
module tb_pad_in_filter;

    localparam int NP = 66;
    localparam int CW = 16;

    logic          clk;
    logic          rst;
    logic [NP-1:0] pad_in;
    logic [NP-1:0] filter_en;
    logic [CW-1:0] filter_cycles;
    logic [NP-1:0] pad_out;
    logic [NP-1:0] rise;
    logic [NP-1:0] fall;

    int checks;
    int errors;

    pad_in_filter #(.NPads(NP), .CntW(CW)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .pad_in_i        (pad_in),
        .filter_en_i     (filter_en),
        .filter_cycles_i (filter_cycles),
        .pad_in_o        (pad_out),
        .rise_o          (rise),
        .fall_o          (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Return all lanes to bypass with input low and let everything drain.
    task automatic settle();
        pad_in        = '0;
        filter_en     = '0;
        filter_cycles = 16'd0;
        for (int k = 0; k < 6; k++) step();
    endtask

    function automatic logic [NP-1:0] lane(input int idx);
        logic [NP-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        logic [NP-1:0] ones;
        ones          = '1;
        rst           = 1'b1;
        pad_in        = ones;
        filter_en     = '0;
        filter_cycles = 16'd0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (pad_out !== '0 || rise !== '0 || fall !== '0) begin
                errors++;
                $display("FAIL reset_hold step %0d: out=%h rise=%h fall=%h want all 0", k, pad_out, rise, fall);
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (k < 3) begin
                if (pad_out !== '0 || rise !== '0) begin
                    errors++;
                    $display("FAIL reset_release edge %0d: out=%h rise=%h want 0", k, pad_out, rise);
                end
            end else if (k == 3) begin
                if (pad_out !== ones || rise !== ones || fall !== '0) begin
                    errors++;
                    $display("FAIL reset_release_rise edge 3: out=%h rise=%h fall=%h want out/rise all-ones", pad_out, rise, fall);
                end
            end else begin
                if (pad_out !== ones || rise !== '0) begin
                    errors++;
                    $display("FAIL reset_rise_once edge 4: out=%h rise=%h want out ones rise 0", pad_out, rise);
                end
            end
        end
    endtask

    task automatic test_bypass();
        logic [NP-1:0] b5;
        b5 = lane(5);
        settle();
        for (int dir = 0; dir < 2; dir++) begin
            pad_in = (dir == 0) ? b5 : '0;
            for (int k = 1; k <= 4; k++) begin
                step();
                checks++;
                if (k < 3) begin
                    if (pad_out !== ((dir == 0) ? '0 : b5) || rise !== '0 || fall !== '0) begin
                        errors++;
                        $display("FAIL bypass_latency dir %0d edge %0d: out=%h rise=%h fall=%h", dir, k, pad_out, rise, fall);
                    end
                end else if (k == 3) begin
                    if (pad_out !== ((dir == 0) ? b5 : '0) ||
                        rise !== ((dir == 0) ? b5 : '0) || fall !== ((dir == 0) ? '0 : b5)) begin
                        errors++;
                        $display("FAIL bypass_edge dir %0d edge 3: out=%h rise=%h fall=%h", dir, pad_out, rise, fall);
                    end
                end else begin
                    if (rise !== '0 || fall !== '0) begin
                        errors++;
                        $display("FAIL bypass_pulse_width dir %0d: rise=%h fall=%h want 0", dir, rise, fall);
                    end
                end
            end
        end
    endtask

    task automatic test_filter_glitch();
        logic [NP-1:0] b32;
        b32 = lane(32);
        settle();
        filter_en     = b32;
        filter_cycles = 16'd4;
        // 4-cycle glitch: rejected.
        pad_in = b32;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 4) pad_in = '0;
            checks++;
            if (pad_out !== '0 || rise !== '0 || fall !== '0) begin
                errors++;
                $display("FAIL filter_glitch edge %0d: out=%h rise=%h fall=%h want 0", k, pad_out, rise, fall);
            end
        end
        // 5-cycle pulse: accepted at edge 3+T=7, released at edge 12.
        pad_in = b32;
        for (int k = 1; k <= 13; k++) begin
            step();
            if (k == 5) pad_in = '0;
            checks++;
            if (pad_out !== ((k >= 7 && k <= 11) ? b32 : '0) ||
                rise !== ((k == 7) ? b32 : '0) || fall !== ((k == 12) ? b32 : '0)) begin
                errors++;
                $display("FAIL filter_pulse edge %0d: out=%h rise=%h fall=%h", k, pad_out, rise, fall);
            end
        end
    endtask

    task automatic test_disable_mid_count();
        logic [NP-1:0] b40;
        b40 = lane(40);
        settle();
        filter_en     = b40;
        filter_cycles = 16'd10;
        pad_in        = b40;
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if (pad_out !== '0) begin
                errors++;
                $display("FAIL disable_precount edge %0d: out=%h want 0", k, pad_out);
            end
        end
        // Counter is at 6 here; dropping the enable commits s2 at this edge.
        filter_en = '0;
        step();
        checks++;
        if (pad_out !== b40 || rise !== b40) begin
            errors++;
            $display("FAIL disable_commit: out=%h rise=%h want %h", pad_out, rise, b40);
        end
        // Re-enable and fall: full 3+T latency from a fresh counter.
        filter_en = b40;
        pad_in    = '0;
        for (int k = 1; k <= 13; k++) begin
            step();
            checks++;
            if (pad_out !== ((k < 13) ? b40 : '0) || fall !== ((k == 13) ? b40 : '0)) begin
                errors++;
                $display("FAIL reenable_fall edge %0d: out=%h fall=%h", k, pad_out, fall);
            end
        end
    endtask

    task automatic test_lower_threshold();
        logic [NP-1:0] b20;
        b20 = lane(20);
        settle();
        filter_en     = b20;
        filter_cycles = 16'd20;
        pad_in        = b20;
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            if (pad_out !== '0) begin
                errors++;
                $display("FAIL lower_t_precount edge %0d: out=%h want 0", k, pad_out);
            end
        end
        // Counter is at 10; T drops to 3 so the next edge commits.
        filter_cycles = 16'd3;
        step();
        checks++;
        if (pad_out !== b20 || rise !== b20) begin
            errors++;
            $display("FAIL lower_t_commit: out=%h rise=%h want %h", pad_out, rise, b20);
        end
    endtask

    task automatic test_t0_vs_bypass();
        logic [95:0]   r;
        logic [NP-1:0] v;
        logic [NP-1:0] h0;
        logic [NP-1:0] h1;
        logic [NP-1:0] h2;
        logic [NP-1:0] prev;
        settle();
        h0 = '0; h1 = '0; h2 = '0; prev = '0;
        filter_cycles = 16'd0;
        for (int n = 0; n < 40; n++) begin
            r = {$urandom(), $urandom(), $urandom()};
            v = r[NP-1:0];
            r = {$urandom(), $urandom(), $urandom()};
            filter_en = r[NP-1:0];
            pad_in    = v;
            step();
            prev = h2;
            h2 = h1; h1 = h0; h0 = v;
            checks++;
            if (pad_out !== h2 || rise !== (h2 & ~prev) || fall !== (~h2 & prev)) begin
                errors++;
                $display("FAIL t0_random step %0d: out=%h want %h rise=%h fall=%h", n, pad_out, h2, rise, fall);
            end
        end
    endtask

    task automatic test_lane_independence();
        settle();
        pad_in = lane(65);
        for (int k = 0; k < 5; k++) step();
        for (int k = 0; k < 10; k++) begin
            pad_in[0] = ~pad_in[0];
            step();
            checks++;
            if (pad_out[65] !== 1'b1 || rise[65] !== 1'b0 || fall[65] !== 1'b0) begin
                errors++;
                $display("FAIL lane_independence step %0d: out65=%b rise65=%b fall65=%b want 1/0/0", k, pad_out[65], rise[65], fall[65]);
            end
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        pad_in        = '0;
        filter_en     = '0;
        filter_cycles = 16'd0;
        test_reset();
        test_bypass();
        test_filter_glitch();
        test_disable_mid_count();
        test_lower_threshold();
        test_t0_vs_bypass();
        test_lane_independence();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
